forwarding_scoreboard: RTL and testbench

FORWARDING_SCOREBOARD -- requirements
Module: forwarding_scoreboard

---
 rtl/forwarding_scoreboard_if.sv | 57 +++++
 rtl/forwarding_scoreboard.sv | 91 +++++++++
 tb/tb_forwarding_scoreboard.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/forwarding_scoreboard_if.sv
// Decode/producer/issue bundle for the forwarding scoreboard.
// The slave modport is the scoreboard's side; the master side drives operands and producers.
interface forwarding_scoreboard_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_READ       = 2,
  parameter int LAT_WIDTH      = 3
);
  localparam int PAW = REG_ADDR_WIDTH + 1;

  logic [NUM_READ-1:0]            dec_rd_enable;
  logic [NUM_READ*PAW-1:0]        dec_rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] dec_rd_data;

  logic                           exec_wb_reg;
  logic                           exec_is_alu;
  logic [PAW-1:0]                 exec_write_addr;
  logic [DATA_WIDTH-1:0]          exec_write;

  logic                           mem_wb_reg;
  logic [PAW-1:0]                 mem_write_addr;
  logic [DATA_WIDTH-1:0]          mem_write;

  logic                           wb_wb_reg;
  logic [PAW-1:0]                 wb_write_addr;
  logic [DATA_WIDTH-1:0]          wb_write;

  logic                           iss_valid;
  logic [PAW-1:0]                 iss_addr;
  logic [LAT_WIDTH-1:0]           iss_latency;

  logic                           flush;

  logic [NUM_READ*DATA_WIDTH-1:0] dec_rd_override;
  logic                           stall;
  logic [15:0]                    stall_count;

  modport slave (
    input  dec_rd_enable, dec_rd_addr, dec_rd_data,
    input  exec_wb_reg, exec_is_alu, exec_write_addr, exec_write,
    input  mem_wb_reg, mem_write_addr, mem_write,
    input  wb_wb_reg, wb_write_addr, wb_write,
    input  iss_valid, iss_addr, iss_latency,
    input  flush,
    output dec_rd_override, stall, stall_count
  );

  modport master (
    output dec_rd_enable, dec_rd_addr, dec_rd_data,
    output exec_wb_reg, exec_is_alu, exec_write_addr, exec_write,
    output mem_wb_reg, mem_write_addr, mem_write,
    output wb_wb_reg, wb_write_addr, wb_write,
    output iss_valid, iss_addr, iss_latency,
    output flush,
    input  dec_rd_override, stall, stall_count
  );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Operand forwarding mux plus per-register pending-latency scoreboard.
// It raises a decode stall on load-use hazards or on reads of registers that are still pending.
module forwarding_scoreboard #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_READ       = 2,
  parameter int LAT_WIDTH      = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  forwarding_scoreboard_if.slave  bus
);
  localparam int PAW      = REG_ADDR_WIDTH + 1;
  localparam int NUM_REGS = 1 << PAW;

  logic [LAT_WIDTH-1:0] pendCnt_q [NUM_REGS];
  logic [LAT_WIDTH-1:0] pendCnt_d [NUM_REGS];
  logic [15:0]          stallCnt_q;
  logic [15:0]          stallCnt_d;
  logic [NUM_READ-1:0]  portStall;
  logic                 stallNow;

  // Everything is qualified by rst_n so that reset passes rd_data through and never stalls.
  for (genvar i = 0; i < NUM_READ; i++) begin : g_port
    logic [PAW-1:0]        addr;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  live;
    logic                  execHit;
    logic                  memHit;
    logic                  wbHit;
    logic                  pending;

    assign addr    = bus.dec_rd_addr[i*PAW +: PAW];
    assign rdData  = bus.dec_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign live    = rst_n & bus.dec_rd_enable[i] & (addr != '0);
    assign execHit = live & bus.exec_wb_reg & (bus.exec_write_addr == addr);
    assign memHit  = live & bus.mem_wb_reg  & (bus.mem_write_addr  == addr);
    assign wbHit   = live & bus.wb_wb_reg   & (bus.wb_write_addr   == addr);
    assign pending = live & (pendCnt_q[addr] != '0);

    // A load in execute has no data yet, so it stalls but does not forward.
    assign portStall[i] = (execHit & ~bus.exec_is_alu) | (pending & ~memHit & ~wbHit);

    assign bus.dec_rd_override[i*DATA_WIDTH +: DATA_WIDTH] =
      (execHit & bus.exec_is_alu) ? bus.exec_write :
      memHit                      ? bus.mem_write  :
      wbHit                       ? bus.wb_write   : rdData;
  end

  assign stallNow        = |portStall;
  assign bus.stall       = stallNow;
  assign bus.stall_count = stallCnt_q;

  // Priority from lowest to highest: decrement, write-back clear, issue load, flush.
  always_comb begin
    for (int j = 0; j < NUM_REGS; j++) begin
      pendCnt_d[j] = pendCnt_q[j];
      if (pendCnt_q[j] != '0) begin
        pendCnt_d[j] = pendCnt_q[j] - 1'b1;
      end
      if (bus.wb_wb_reg && (bus.wb_write_addr == PAW'(j)) && (pendCnt_q[j] != '0)) begin
        pendCnt_d[j] = '0;
      end
      if (bus.iss_valid && (bus.iss_addr == PAW'(j))) begin
        pendCnt_d[j] = bus.iss_latency;
      end
      if (bus.flush || (j == 0)) begin
        pendCnt_d[j] = '0;
      end
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (stallNow && !bus.flush && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_REGS; j++) begin
        pendCnt_q[j] <= '0;
      end
      stallCnt_q <= '0;
    end else begin
      pendCnt_q  <= pendCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: a table of combinational forwarding vectors
// followed by hand-written multi-cycle sequences for the scoreboard, flush and reset.
module tb_forwarding_scoreboard;
  localparam int DW  = 32;
  localparam int PAW = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  forwarding_scoreboard_if bus();

  forwarding_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]     en;
    logic [PAW-1:0] a0;
    logic [PAW-1:0] a1;
    logic [DW-1:0]  d0;
    logic [DW-1:0]  d1;
    logic           exWb;
    logic           exAlu;
    logic [PAW-1:0] exAddr;
    logic [DW-1:0]  exData;
    logic           memWb;
    logic [PAW-1:0] memAddr;
    logic [DW-1:0]  memData;
    logic           wbWb;
    logic [PAW-1:0] wbAddr;
    logic [DW-1:0]  wbData;
    logic [DW-1:0]  exp0;
    logic [DW-1:0]  exp1;
    logic           expStall;
  } vec_t;

  vec_t vecs [10];

  task automatic clearInputs();
    bus.dec_rd_enable   = '0;
    bus.dec_rd_addr     = '0;
    bus.dec_rd_data     = '0;
    bus.exec_wb_reg     = 1'b0;
    bus.exec_is_alu     = 1'b0;
    bus.exec_write_addr = '0;
    bus.exec_write      = '0;
    bus.mem_wb_reg      = 1'b0;
    bus.mem_write_addr  = '0;
    bus.mem_write       = '0;
    bus.wb_wb_reg       = 1'b0;
    bus.wb_write_addr   = '0;
    bus.wb_write        = '0;
    bus.iss_valid       = 1'b0;
    bus.iss_addr        = '0;
    bus.iss_latency     = '0;
    bus.flush           = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.dec_rd_enable   = v.en;
    bus.dec_rd_addr     = {v.a1, v.a0};
    bus.dec_rd_data     = {v.d1, v.d0};
    bus.exec_wb_reg     = v.exWb;
    bus.exec_is_alu     = v.exAlu;
    bus.exec_write_addr = v.exAddr;
    bus.exec_write      = v.exData;
    bus.mem_wb_reg      = v.memWb;
    bus.mem_write_addr  = v.memAddr;
    bus.mem_write       = v.memData;
    bus.wb_wb_reg       = v.wbWb;
    bus.wb_write_addr   = v.wbAddr;
    bus.wb_write        = v.wbData;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setRead0(input logic [PAW-1:0] addr, input logic [DW-1:0] data);
    bus.dec_rd_enable[0]         = 1'b1;
    bus.dec_rd_addr[0 +: PAW]    = addr;
    bus.dec_rd_data[0 +: DW]     = data;
  endtask

  task automatic issue(input logic [PAW-1:0] addr, input logic [2:0] lat);
    bus.iss_valid   = 1'b1;
    bus.iss_addr    = addr;
    bus.iss_latency = lat;
  endtask

  // Leaves the bench 1 time unit after a rising edge, the window where inputs change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    clearInputs();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{en:2'b01, a0:6'd5, d0:32'h11, a1:6'd0, d1:32'h22, exWb:1'b1, exAlu:1'b1,
                exAddr:6'd5, exData:32'hAA, memWb:1'b1, memAddr:6'd5, memData:32'hBB,
                exp0:32'hAA, exp1:32'h22, default:'0};
    vecs[1] = '{en:2'b11, a0:6'd8, d0:32'h1, a1:6'd9, d1:32'h2, exWb:1'b1, exAlu:1'b1,
                exAddr:6'd9, exData:32'h99, memWb:1'b1, memAddr:6'd8, memData:32'hBB,
                wbWb:1'b1, wbAddr:6'd8, wbData:32'hCC, exp0:32'hBB, exp1:32'h99, default:'0};
    vecs[2] = '{en:2'b11, a0:6'd3, d0:32'h33, a1:6'd12, d1:32'h44, wbWb:1'b1, wbAddr:6'd12,
                wbData:32'hDD, exp0:32'h33, exp1:32'hDD, default:'0};
    vecs[3] = '{en:2'b11, a0:6'd0, d0:32'h55, a1:6'd0, d1:32'h66, exWb:1'b1, exAlu:1'b0,
                exAddr:6'd0, exData:32'hAA, memWb:1'b1, memAddr:6'd0, memData:32'hBB,
                wbWb:1'b1, wbAddr:6'd0, wbData:32'hCC, exp0:32'h55, exp1:32'h66, default:'0};
    vecs[4] = '{en:2'b00, a0:6'd5, d0:32'h11, a1:6'd5, d1:32'h22, exWb:1'b1, exAlu:1'b1,
                exAddr:6'd5, exData:32'hAA, exp0:32'h11, exp1:32'h22, default:'0};
    vecs[5] = '{en:2'b10, a0:6'd7, d0:32'h77, a1:6'd2, d1:32'h88, exWb:1'b1, exAlu:1'b0,
                exAddr:6'd7, exData:32'h12, exp0:32'h77, exp1:32'h88, default:'0};
    vecs[6] = '{en:2'b01, a0:6'd7, d0:32'h77, a1:6'd0, d1:32'h88, exWb:1'b1, exAlu:1'b0,
                exAddr:6'd7, exData:32'h12, memWb:1'b1, memAddr:6'd7, memData:32'hEE,
                exp0:32'hEE, exp1:32'h88, expStall:1'b1, default:'0};
    vecs[7] = '{en:2'b11, a0:6'd4, d0:32'h40, a1:6'd1, d1:32'h10, exWb:1'b0, exAlu:1'b1,
                exAddr:6'd4, exData:32'hAA, wbWb:1'b1, wbAddr:6'd4, wbData:32'h77,
                exp0:32'h77, exp1:32'h10, default:'0};
    vecs[8] = '{en:2'b11, a0:6'd10, d0:32'h1, a1:6'd11, d1:32'h2, exWb:1'b1, exAlu:1'b1,
                exAddr:6'd10, exData:32'hAA, memWb:1'b1, memAddr:6'd11, memData:32'hBB,
                exp0:32'hAA, exp1:32'hBB, default:'0};
    vecs[9] = '{en:2'b11, a0:6'd3, d0:32'h30, a1:6'd7, d1:32'h70, exWb:1'b1, exAlu:1'b0,
                exAddr:6'd7, exData:32'h12, exp0:32'h30, exp1:32'h70, expStall:1'b1, default:'0};

    // Reset state: a load-use hazard with a mem match is presented but must be suppressed.
    rst_n = 1'b0;
    clearInputs();
    applyStimulus(vecs[6]);
    #3;
    checkOutput("reset_stall", 32'(bus.stall), 32'h0);
    checkOutput("reset_ov0", bus.dec_rd_override[31:0], 32'h77);
    checkOutput("reset_count", 32'(bus.stall_count), 32'h0);
    step();
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      applyStimulus(vecs[k]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_ov0", k), bus.dec_rd_override[31:0], vecs[k].exp0);
      checkOutput($sformatf("vec%0d_ov1", k), bus.dec_rd_override[63:32], vecs[k].exp1);
      checkOutput($sformatf("vec%0d_stall", k), 32'(bus.stall), 32'(vecs[k].expStall));
      step();
    end

    // Load-use on port 1, resolved by mem forwarding one cycle later.
    pulseReset();
    bus.dec_rd_enable = 2'b10;
    bus.dec_rd_addr   = {6'd7, 6'd0};
    bus.dec_rd_data   = {32'h22, 32'h11};
    bus.exec_wb_reg   = 1'b1;
    bus.exec_write_addr = 6'd7;
    @(negedge clk);
    checkOutput("loaduse_stall", 32'(bus.stall), 32'h1);
    step();
    bus.exec_wb_reg    = 1'b0;
    bus.mem_wb_reg     = 1'b1;
    bus.mem_write_addr = 6'd7;
    bus.mem_write      = 32'hCC;
    @(negedge clk);
    checkOutput("loaduse_ov1", bus.dec_rd_override[63:32], 32'hCC);
    checkOutput("loaduse_stall2", 32'(bus.stall), 32'h0);
    checkOutput("loaduse_count", 32'(bus.stall_count), 32'h1);

    // Issue latency 3 gives exactly three pending cycles.
    pulseReset();
    issue(6'd9, 3'd3);
    @(negedge clk);
    checkOutput("lat3_issue_stall", 32'(bus.stall), 32'h0);
    step();
    bus.iss_valid = 1'b0;
    setRead0(6'd9, 32'h90);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("lat3_stall%0d", k), 32'(bus.stall), 32'h1);
      step();
    end
    @(negedge clk);
    checkOutput("lat3_done", 32'(bus.stall), 32'h0);
    checkOutput("lat3_count", 32'(bus.stall_count), 32'h3);

    // Reissue while the entry holds 1: the reload wins over the decrement.
    pulseReset();
    issue(6'd4, 3'd2);
    step();
    bus.iss_valid = 1'b0;
    setRead0(6'd4, 32'h40);
    @(negedge clk);
    checkOutput("reload_pre2", 32'(bus.stall), 32'h1);
    step();
    issue(6'd4, 3'd5);
    @(negedge clk);
    checkOutput("reload_pre1", 32'(bus.stall), 32'h1);
    step();
    bus.iss_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("reload_stall%0d", k), 32'(bus.stall), 32'h1);
      step();
    end
    @(negedge clk);
    checkOutput("reload_done", 32'(bus.stall), 32'h0);
    checkOutput("reload_count", 32'(bus.stall_count), 32'h7);

    // A write-back match forwards and retires the pending entry.
    pulseReset();
    issue(6'd3, 3'd5);
    step();
    bus.iss_valid = 1'b0;
    setRead0(6'd3, 32'h33);
    bus.wb_wb_reg     = 1'b1;
    bus.wb_write_addr = 6'd3;
    bus.wb_write      = 32'hDD;
    @(negedge clk);
    checkOutput("wbclr_ov0", bus.dec_rd_override[31:0], 32'hDD);
    checkOutput("wbclr_stall", 32'(bus.stall), 32'h0);
    step();
    bus.wb_wb_reg = 1'b0;
    @(negedge clk);
    checkOutput("wbclr_after", 32'(bus.stall), 32'h0);
    checkOutput("wbclr_ov0b", bus.dec_rd_override[31:0], 32'h33);

    // Flush: still stalls during the flush cycle but does not count it.
    pulseReset();
    issue(6'd6, 3'd7);
    step();
    bus.iss_valid = 1'b0;
    bus.flush     = 1'b1;
    setRead0(6'd6, 32'h66);
    @(negedge clk);
    checkOutput("flush_stall", 32'(bus.stall), 32'h1);
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_after", 32'(bus.stall), 32'h0);
    checkOutput("flush_count", 32'(bus.stall_count), 32'h0);

    // Asynchronous reset in the middle of a countdown.
    step();
    issue(6'd6, 3'd7);
    bus.dec_rd_enable = '0;
    step();
    bus.iss_valid = 1'b0;
    setRead0(6'd6, 32'h66);
    bus.mem_wb_reg     = 1'b1;
    bus.mem_write_addr = 6'd1;
    bus.mem_write      = 32'hBB;
    @(negedge clk);
    checkOutput("midrst_pre", 32'(bus.stall), 32'h1);
    step();
    @(negedge clk);
    checkOutput("midrst_count_pre", 32'(bus.stall_count), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_stall", 32'(bus.stall), 32'h0);
    checkOutput("midrst_count", 32'(bus.stall_count), 32'h0);
    checkOutput("midrst_ov0", bus.dec_rd_override[31:0], 32'h66);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_after", 32'(bus.stall), 32'h0);
    checkOutput("midrst_count_after", 32'(bus.stall_count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
